// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences IF/ID/EXE/MEM/WB
// and drives every datapath select and enable, stalling on Mem_Rdy.
//
// state | meaning
// IF    | fetch: read memory at PC, load PC+4 and IR once Mem_Rdy
// ID    | decode: latch Op/Func, precompute branch target, retire j
// EXE   | ALU operation / address calc / beq compare
// MEM   | lw/sw data access, held until Mem_Rdy
// WB    | register-file write
// HALT  | illegal opcode trap, left only through reset
module mc_control_unit #(
    parameter bit TRAP_EN = 1'b0
) (
    input  logic       Clk,
    input  logic       Clrn,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Z,
    input  logic       Mem_Rdy,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUC,
    output logic [1:0] PCSource,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [2:0] State,
    output logic       Halt
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] func_q;

    // ID decodes the live IR fields; later states use the copy taken in ID
    logic [5:0] dec_op;
    logic [5:0] dec_func;
    assign dec_op   = (state == S_ID) ? Op   : op_q;
    assign dec_func = (state == S_ID) ? Func : func_q;

    logic       is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, func_ok, legal;
    logic [2:0] r_aluc;

    always_comb begin
        is_r    = (dec_op == OP_R);
        is_addi = (dec_op == OP_ADDI);
        is_ori  = (dec_op == OP_ORI);
        is_lw   = (dec_op == OP_LW);
        is_sw   = (dec_op == OP_SW);
        is_beq  = (dec_op == OP_BEQ);
        is_j    = (dec_op == OP_J);
        func_ok = 1'b1;
        r_aluc  = 3'b000;
        case (dec_func)
            6'b100000: r_aluc = 3'b000;
            6'b100010: r_aluc = 3'b001;
            6'b100100: r_aluc = 3'b010;
            6'b100101: r_aluc = 3'b011;
            default:   func_ok = 1'b0;
        endcase
        legal = (is_r && func_ok) || is_addi || is_ori || is_lw || is_sw || is_beq || is_j;
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state  <= S_IF;
            op_q   <= 6'd0;
            func_q <= 6'd0;
        end else begin
            case (state)
                S_IF:  if (Mem_Rdy) state <= S_ID;
                S_ID: begin
                    op_q   <= Op;
                    func_q <= Func;
                    if (!legal)    state <= TRAP_EN ? S_HALT : S_IF;
                    else if (is_j) state <= S_IF;
                    else           state <= S_EXE;
                end
                S_EXE: begin
                    if (is_beq)             state <= S_IF;
                    else if (is_lw || is_sw) state <= S_MEM;
                    else                    state <= S_WB;
                end
                S_MEM: if (Mem_Rdy) state <= is_lw ? S_WB : S_IF;
                S_WB:   state <= S_IF;
                S_HALT: state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUC     = 3'b000;
        PCSource = 2'b00;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        State    = state;
        Halt     = 1'b0;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = Mem_Rdy;
                IRWrite = Mem_Rdy;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                if (is_j) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                if (is_r) begin
                    ALUC = r_aluc;
                end else if (is_beq) begin
                    ALUC     = 3'b001;
                    PCSource = 2'b01;
                    PCWrite  = Z;
                end else begin
                    ALUSrcB = 2'b10;
                    if (is_ori) ALUC = 3'b011;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_r;
                MemtoReg = is_lw;
            end
            S_HALT: Halt = 1'b1;
            default: ;
        endcase
    end
endmodule
